seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-division scan controller for the board's 8-digit seven-segment display. It owns `seg_cs_pin` and the two shared segment buses, and cycles one digit at a time at a programmable slot rate. It accepts a full 8-digit frame over a valid/ready handshake and commits it only at a frame boundary, so no tearing is visible. It sits between the counter/datapath logic and the display pins, replacing per-block direct pin driving.

## Interface
- `SCAN_DIV`, default 100: clock cycles per digit slot; must be ≥2 (simulation value; board build uses 100000).
- `DEAD_CYCLES`, default 10: blanking cycles at the start of each slot; must be < `SCAN_DIV`; used only with `SEG_DEAD_TIME_EN`.
- `sys_clk_in`  in  1  system clock, 100 MHz.
- `sys_rst`  in  1  synchronous reset, active-high.
- `scan_en`  in  1  1 = scan running; 0 = display dark.
- `load_valid`  in  1  frame offered.
- `load_ready`  out  1  shadow buffer empty; a frame is accepted when `load_valid && load_ready`.
- `load_digits`  in  32  digit i value = `[4i+3:4i]`, hex 0–F.
- `load_blank`  in  8  bit i = 1 forces digit i blank.
- `frame_start`  out  1  one-cycle pulse on the first cycle of the digit-0 slot.
- `seg_cs_pin`  out  8  one-hot digit select, active-high.
- `seg_data_0_pin`  out  8  segments for digits 0–3, active-low.
- `seg_data_1_pin`  out  8  segments for digits 4–7, active-low.

## Operation
- States: IDLE (`scan_en` = 0) and SCAN. IDLE→SCAN when `scan_en` rises; the first SCAN cycle is digit 0, slot cycle 0. SCAN→IDLE in the cycle after `scan_en` falls, from any position.
- Counters: `slot_cnt` runs 0..`SCAN_DIV`-1. `digit_idx` (3 bits) advances when `slot_cnt` wraps, going 7→0. Both hold at 0 in IDLE.
- Two register sets, each holding 32 digit bits and 8 blank bits: shadow and displayed.
- Accept: on handshake, the shadow is written and `load_ready` drops the next cycle.
- Commit: on the edge that enters digit 0 (wrap 7→0, or IDLE→SCAN), the displayed set takes the shadow if it is full, and `load_ready` returns to 1 the next cycle.
- No new accept occurs in the commit cycle, because `load_ready` is still 0.
- Pending shadow is kept across IDLE and commits at the next frame start.
- Active slot, digit i < 4: `seg_cs_pin` = 1<<i, `seg_data_0_pin` = glyph(i), `seg_data_1_pin` = 8'hFF.
- Active slot, digit i ≥ 4: `seg_cs_pin` = 1<<i, `seg_data_1_pin` = glyph(i), `seg_data_0_pin` = 8'hFF.
- Glyph encoding, active-low {dp,g..a}:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - A=08, B=00, C=46, D=40, E=06, F=0E (lit dp marks A–F).
  - Blank digit = FF.
- IDLE outputs: `seg_cs_pin` = 00, both data buses = FF, `frame_start` = 0.

## Timing
- Reset values: `seg_cs_pin` = 00, `seg_data_0_pin` = `seg_data_1_pin` = FF, `load_ready` = 1, `frame_start` = 0.
- On reset, the state goes to IDLE and the counters clear.
- On reset, the displayed blank mask = FF, digit values = 0, and the shadow is empty.
- Reset mid-scan or mid-handshake discards any pending frame.
- All outputs are registered. Pins reflect the current `digit_idx`/`slot_cnt` one cycle after the counters update. `frame_start` is aligned with the first pin cycle of digit 0.
- Frame period = 8 × `SCAN_DIV` cycles.
- Load-to-display latency: from acceptance to the next digit-0 slot, between 1 and 8 × `SCAN_DIV` cycles.
- `load_digits`/`load_blank` are sampled only on the handshake cycle; they may change freely otherwise.

## Configuration
- `SEG_DEAD_TIME_EN` defined:
  - Slot cycles 0..`DEAD_CYCLES`-1 drive `seg_cs_pin` = 00 and both buses = FF (anti-ghosting).
  - The remaining cycles of the slot are active.
  - `frame_start` still pulses on slot cycle 0 of digit 0.
- Not defined: the whole slot is active and `DEAD_CYCLES` is ignored.

## Structure
- Package `seg_pkg`:
  - glyph constants `SEG_NUM_0`..`SEG_NUM_F` and `SEG_BLANK`;
  - state enum `scan_state_t` {IDLE, SCAN};
  - constant `SEG_DIGITS` = 8.
- Sub-module `seg_hex_decode`: combinational; 4-bit value + blank in, 8-bit active-low glyph out; one instance on the muxed digit.

## Test plan
- Reset check: hold `sys_rst` 2 cycles during SCAN → `seg_cs_pin` = 00, buses = FF, `load_ready` = 1, `frame_start` = 0 from the next cycle.
- Full frame, `SCAN_DIV` = 4, no macro: load 0x76543210, blank = 00, `scan_en` = 1.
  - `seg_cs_pin` steps 01,02,…,80, each for 4 cycles.
  - `seg_data_0_pin` = C0,F9,A4,B0 on cs 01–08 and FF otherwise.
  - `seg_data_1_pin` = 99,92,82,F8 on cs 10–80 and FF otherwise.
- Mid-frame load: accept 0xFFFFFFFF during digit 3.
  - `load_ready` = 0 until the cycle after commit.
  - Digits 4–7 still show old values.
  - Next digit-0 slot shows 0E with dp lit on all digits.
- Blank mask: digit 2 = A with `load_blank` = 04 → FF during cs 04; with `load_blank` = 00 → 08.
- Dead time, `SEG_DEAD_TIME_EN`, `SCAN_DIV` = 4, `DEAD_CYCLES` = 1: each slot shows 1 cycle of cs 00 with buses FF, then 3 active cycles.
- `scan_en` dropped at digit 5 with a pending frame:
  - Pins go dark the next cycle.
  - On re-enable, `frame_start` pulses, the pending frame commits, and `load_ready` returns to 1.
  - Repeat with `sys_rst` instead of `scan_en`: the frame is discarded and the display is blank.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan controller.
//   - SEG_DIGITS      : number of multiplexed digits on the board
//   - SEG_NUM_0..F    : active-low glyphs {dp,g,f,e,d,c,b,a}; dp is lit on A-F
//   - SEG_BLANK       : all segments off
//   - scan_state_t    : scan controller state encoding
package seg_pkg;

    localparam int unsigned SEG_DIGITS = 8;

    localparam logic [7:0] SEG_NUM_0 = 8'hC0;
    localparam logic [7:0] SEG_NUM_1 = 8'hF9;
    localparam logic [7:0] SEG_NUM_2 = 8'hA4;
    localparam logic [7:0] SEG_NUM_3 = 8'hB0;
    localparam logic [7:0] SEG_NUM_4 = 8'h99;
    localparam logic [7:0] SEG_NUM_5 = 8'h92;
    localparam logic [7:0] SEG_NUM_6 = 8'h82;
    localparam logic [7:0] SEG_NUM_7 = 8'hF8;
    localparam logic [7:0] SEG_NUM_8 = 8'h80;
    localparam logic [7:0] SEG_NUM_9 = 8'h90;
    localparam logic [7:0] SEG_NUM_A = 8'h08;
    localparam logic [7:0] SEG_NUM_B = 8'h00;
    localparam logic [7:0] SEG_NUM_C = 8'h46;
    localparam logic [7:0] SEG_NUM_D = 8'h40;
    localparam logic [7:0] SEG_NUM_E = 8'h06;
    localparam logic [7:0] SEG_NUM_F = 8'h0E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex-to-seven-segment decoder.
//   value : 4-bit hex digit
//   blank : 1 forces all segments off
//   glyph : active-low segment pattern {dp,g..a}
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        if (!blank) begin
            unique case (value)
                4'h0: glyph = SEG_NUM_0;
                4'h1: glyph = SEG_NUM_1;
                4'h2: glyph = SEG_NUM_2;
                4'h3: glyph = SEG_NUM_3;
                4'h4: glyph = SEG_NUM_4;
                4'h5: glyph = SEG_NUM_5;
                4'h6: glyph = SEG_NUM_6;
                4'h7: glyph = SEG_NUM_7;
                4'h8: glyph = SEG_NUM_8;
                4'h9: glyph = SEG_NUM_9;
                4'hA: glyph = SEG_NUM_A;
                4'hB: glyph = SEG_NUM_B;
                4'hC: glyph = SEG_NUM_C;
                4'hD: glyph = SEG_NUM_D;
                4'hE: glyph = SEG_NUM_E;
                4'hF: glyph = SEG_NUM_F;
                default: glyph = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-division scan controller for the 8-digit display.
//   sys_clk_in / sys_rst : clock, synchronous active-high reset
//   scan_en              : 1 = scanning, 0 = display dark
//   load_valid/ready     : frame handshake; load_digits (8 x 4 bit hex),
//                          load_blank (per-digit blank) sampled on handshake
//   frame_start          : pulse on first pin cycle of the digit-0 slot
//   seg_cs_pin           : one-hot digit select, active-high
//   seg_data_0/1_pin     : active-low segments for digits 0-3 / 4-7
// Optional feature: define SEG_DEAD_TIME_EN to blank the first DEAD_CYCLES
// cycles of every slot (anti-ghosting).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 100,
    parameter int unsigned DEAD_CYCLES = 10
) (
    input  logic                  sys_clk_in,
    input  logic                  sys_rst,
    input  logic                  scan_en,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [31:0]           load_digits,
    input  logic [SEG_DIGITS-1:0] load_blank,
    output logic                  frame_start,
    output logic [SEG_DIGITS-1:0] seg_cs_pin,
    output logic [7:0]            seg_data_0_pin,
    output logic [7:0]            seg_data_1_pin
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

    if (SCAN_DIV < 2 || DEAD_CYCLES >= SCAN_DIV) begin : g_bad_cfg
        $error("seg_scan_ctrl: need SCAN_DIV >= 2 and DEAD_CYCLES < SCAN_DIV");
    end

    scan_state_t           state_q, state_d;
    logic [CW-1:0]         slot_cnt_q, slot_cnt_d;
    logic [2:0]            digit_idx_q, digit_idx_d;
    logic [31:0]           shadow_digits_q, shadow_digits_d;
    logic [SEG_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
    logic [31:0]           disp_digits_q, disp_digits_d;
    logic [SEG_DIGITS-1:0] disp_blank_q, disp_blank_d;
    logic                  load_ready_q, load_ready_d;
    logic [SEG_DIGITS-1:0] cs_q, cs_d;
    logic [7:0]            data0_q, data0_d;
    logic [7:0]            data1_q, data1_d;
    logic                  frame_start_q, frame_start_d;

    logic                  commit;
    logic                  run_now;
    logic                  pins_active;
    logic [3:0]            cur_val;
    logic                  cur_blank;
    logic [7:0]            glyph;

    // State and slot/digit counters; commit marks the edge entering digit 0.
    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        digit_idx_d = digit_idx_q;
        commit      = 1'b0;
        unique case (state_q)
            IDLE: begin
                slot_cnt_d  = '0;
                digit_idx_d = '0;
                if (scan_en) begin
                    state_d = SCAN;
                    commit  = 1'b1;
                end
            end
            SCAN: begin
                if (!scan_en) begin
                    state_d     = IDLE;
                    slot_cnt_d  = '0;
                    digit_idx_d = '0;
                end else if (slot_cnt_q == SLOT_LAST) begin
                    slot_cnt_d  = '0;
                    digit_idx_d = digit_idx_q + 3'd1;
                    commit      = (digit_idx_q == 3'd7);
                end else begin
                    slot_cnt_d = slot_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow/displayed buffers. load_ready_q doubles as "shadow empty", so an
    // accept (needs ready=1) and a commit (needs ready=0) never coincide.
    always_comb begin
        shadow_digits_d = shadow_digits_q;
        shadow_blank_d  = shadow_blank_q;
        disp_digits_d   = disp_digits_q;
        disp_blank_d    = disp_blank_q;
        load_ready_d    = load_ready_q;
        if (commit && !load_ready_q) begin
            disp_digits_d = shadow_digits_q;
            disp_blank_d  = shadow_blank_q;
            load_ready_d  = 1'b1;
        end else if (load_valid && load_ready_q) begin
            shadow_digits_d = load_digits;
            shadow_blank_d  = load_blank;
            load_ready_d    = 1'b0;
        end
    end

    assign cur_val   = 4'(disp_digits_q >> {digit_idx_q, 2'b00});
    assign cur_blank = disp_blank_q[digit_idx_q];

    seg_hex_decode u_decode (
        .value (cur_val),
        .blank (cur_blank),
        .glyph (glyph)
    );

    // Pins are registered from the current counters; gating with scan_en
    // darkens them on the same edge the state returns to IDLE.
    always_comb begin
        run_now = (state_q == SCAN) && scan_en;
`ifdef SEG_DEAD_TIME_EN
        pins_active = run_now && (slot_cnt_q >= CW'(DEAD_CYCLES));
`else
        pins_active = run_now;
`endif
        cs_d          = '0;
        data0_d       = SEG_BLANK;
        data1_d       = SEG_BLANK;
        frame_start_d = run_now && (slot_cnt_q == '0) && (digit_idx_q == '0);
        if (pins_active) begin
            cs_d = 8'b1 << digit_idx_q;
            if (digit_idx_q[2]) data1_d = glyph;
            else                data0_d = glyph;
        end
    end

    always_ff @(posedge sys_clk_in) begin
        if (sys_rst) begin
            state_q         <= IDLE;
            slot_cnt_q      <= '0;
            digit_idx_q     <= '0;
            shadow_digits_q <= '0;
            shadow_blank_q  <= '0;
            disp_digits_q   <= '0;
            disp_blank_q    <= '1;
            load_ready_q    <= 1'b1;
            cs_q            <= '0;
            data0_q         <= SEG_BLANK;
            data1_q         <= SEG_BLANK;
            frame_start_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            slot_cnt_q      <= slot_cnt_d;
            digit_idx_q     <= digit_idx_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_blank_q  <= shadow_blank_d;
            disp_digits_q   <= disp_digits_d;
            disp_blank_q    <= disp_blank_d;
            load_ready_q    <= load_ready_d;
            cs_q            <= cs_d;
            data0_q         <= data0_d;
            data1_q         <= data1_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign load_ready     = load_ready_q;
    assign frame_start    = frame_start_q;
    assign seg_cs_pin     = cs_q;
    assign seg_data_0_pin = data0_q;
    assign seg_data_1_pin = data1_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

`ifdef SEG_DEAD_TIME_EN
    localparam int DEAD = 1;
`else
    localparam int DEAD = 0;
`endif

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        scan_en;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_digits;
    logic [7:0]  load_blank;
    logic        frame_start;
    logic [7:0]  seg_cs_pin;
    logic [7:0]  seg_data_0_pin;
    logic [7:0]  seg_data_1_pin;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SCAN_DIV(4), .DEAD_CYCLES(1)) dut (
        .sys_clk_in     (clk),
        .sys_rst        (sys_rst),
        .scan_en        (scan_en),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_digits    (load_digits),
        .load_blank     (load_blank),
        .frame_start    (frame_start),
        .seg_cs_pin     (seg_cs_pin),
        .seg_data_0_pin (seg_data_0_pin),
        .seg_data_1_pin (seg_data_1_pin)
    );

    typedef struct {
        logic [31:0] digits;
        logic [7:0]  blank;
        logic [63:0] glyphs;   // expected glyph of digit i at [8i+7:8i]
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int k, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%h exp=%h", name, k, got, exp);
        end
    endtask

    task automatic chk_dark(input string tag, input logic exp_ready);
        chk({tag, "_cs"}, -1, seg_cs_pin, 8'h00);
        chk({tag, "_d0"}, -1, seg_data_0_pin, 8'hFF);
        chk({tag, "_d1"}, -1, seg_data_1_pin, 8'hFF);
        chk({tag, "_fs"}, -1, {7'd0, frame_start}, 8'h00);
        chk({tag, "_ready"}, -1, {7'd0, load_ready}, {7'd0, exp_ready});
    endtask

    // Pins expected k cycles after frame_start in a frame showing glyphs g.
    task automatic check_pins(input logic [63:0] g, input int k);
        int d;
        int s;
        logic [7:0] ecs;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] gl;
        d   = k / 4;
        s   = k % 4;
        gl  = g[d*8 +: 8];
        ecs = 8'h00;
        e0  = 8'hFF;
        e1  = 8'hFF;
        if (s >= DEAD) begin
            ecs = 8'(1 << d);
            if (d < 4) e0 = gl;
            else       e1 = gl;
        end
        chk("cs", k, seg_cs_pin, ecs);
        chk("d0", k, seg_data_0_pin, e0);
        chk("d1", k, seg_data_1_pin, e1);
        chk("fs", k, {7'd0, frame_start}, (k == 0) ? 8'h01 : 8'h00);
    endtask

    task automatic run_frame(input logic [63:0] g);
        for (int k = 0; k < 32; k++) begin
            check_pins(g, k);
            chk("ready_frame", k, {7'd0, load_ready}, 8'h01);
            tick();
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (!frame_start && n < 100) begin
            tick();
            n++;
        end
        chk("fs_wait", n, {7'd0, frame_start}, 8'h01);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!load_ready && n < 100) begin
            tick();
            n++;
        end
        chk("ready_wait", n, {7'd0, load_ready}, 8'h01);
    endtask

    task automatic offer(input logic [31:0] dg, input logic [7:0] bl);
        load_valid  = 1'b1;
        load_digits = dg;
        load_blank  = bl;
    endtask

    task automatic withdraw();
        load_valid  = 1'b0;
        load_digits = $urandom;
        load_blank  = 8'($urandom);
    endtask

    vec_t vecs[5];
    logic [63:0] last_g;
    localparam logic [63:0] G_ALL_F   = 64'h0E0E0E0E_0E0E0E0E;
    localparam logic [63:0] G_PENDING = 64'h80_90_08_00_46_40_06_0E;
    localparam logic [63:0] G_BLANK   = 64'hFFFFFFFF_FFFFFFFF;

    initial begin
        vecs[0] = '{32'h76543210, 8'h00, 64'hF8_82_92_99_B0_A4_F9_C0};
        vecs[1] = '{32'h12345678, 8'hF0, 64'hFF_FF_FF_FF_92_82_F8_80};
        vecs[2] = '{32'h00000A00, 8'h04, 64'hC0_C0_C0_C0_C0_FF_C0_C0};
        vecs[3] = '{32'h00000A00, 8'h00, 64'hC0_C0_C0_C0_C0_08_C0_C0};
        vecs[4] = '{32'hFEDCBA98, 8'h00, 64'h0E_06_40_46_00_08_90_80};

        sys_rst     = 1'b1;
        scan_en     = 1'b0;
        load_valid  = 1'b0;
        load_digits = '0;
        load_blank  = '0;
        tick();
        tick();
        sys_rst = 1'b0;
        chk_dark("reset", 1'b1);

        scan_en = 1'b1;
        foreach (vecs[i]) begin
            wait_ready();
            offer(vecs[i].digits, vecs[i].blank);
            tick();
            withdraw();
            chk("ready_after_accept", i, {7'd0, load_ready}, 8'h00);
            wait_ready();
            wait_fs();
            run_frame(vecs[i].glyphs);
        end
        last_g = vecs[4].glyphs;

        // Mid-frame load during digit 3: old frame completes, then all F.
        for (int k = 0; k < 32; k++) begin
            check_pins(last_g, k);
            chk("ready_mid", k, {7'd0, load_ready}, (k <= 12 || k == 31) ? 8'h01 : 8'h00);
            if (k == 12) offer(32'hFFFFFFFF, 8'h00);
            if (k == 13) withdraw();
            tick();
        end
        run_frame(G_ALL_F);

        // scan_en dropped at digit 5 with a pending frame.
        for (int k = 0; k < 22; k++) begin
            check_pins(G_ALL_F, k);
            if (k == 20) offer(32'h89ABCDEF, 8'h00);
            if (k == 21) begin
                chk("ready_pending", k, {7'd0, load_ready}, 8'h00);
                withdraw();
                scan_en = 1'b0;
            end
            tick();
        end
        for (int n = 0; n < 3; n++) begin
            chk_dark("idle", 1'b0);
            tick();
        end
        scan_en = 1'b1;
        tick();
        chk_dark("reenable", 1'b1);
        tick();
        run_frame(G_PENDING);

        // Reset mid-scan with a pending frame: frame discarded, display blank.
        for (int k = 0; k < 22; k++) begin
            check_pins(G_PENDING, k);
            if (k == 20) offer(32'h11111111, 8'h00);
            if (k == 21) begin
                chk("ready_pending_rst", k, {7'd0, load_ready}, 8'h00);
                withdraw();
                sys_rst = 1'b1;
            end
            tick();
        end
        chk_dark("rst1", 1'b1);
        tick();
        chk_dark("rst2", 1'b1);
        sys_rst = 1'b0;
        tick();
        chk_dark("post_rst", 1'b1);
        tick();
        run_frame(G_BLANK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog k=-1 got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
